// File: rtl/mem_read_arbi_rr.sv
// Four-channel round-robin read burst arbiter in front of a single memory controller read port.
// Optional read watchdog: define MEM_READ_ARBI_WDT_EN.
module mem_read_arbi_rr #(
    parameter int MEM_DATA_BITS = 64
) (
    input  logic                     mem_clk,
    input  logic                     rst,

    input  logic                     ch0_rd_burst_req,
    input  logic [9:0]               ch0_rd_burst_len,
    input  logic [23:0]              ch0_rd_burst_addr,
    output logic                     ch0_rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] ch0_rd_burst_data,
    output logic                     ch0_rd_burst_finish,

    input  logic                     ch1_rd_burst_req,
    input  logic [9:0]               ch1_rd_burst_len,
    input  logic [23:0]              ch1_rd_burst_addr,
    output logic                     ch1_rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] ch1_rd_burst_data,
    output logic                     ch1_rd_burst_finish,

    input  logic                     ch2_rd_burst_req,
    input  logic [9:0]               ch2_rd_burst_len,
    input  logic [23:0]              ch2_rd_burst_addr,
    output logic                     ch2_rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] ch2_rd_burst_data,
    output logic                     ch2_rd_burst_finish,

    input  logic                     ch3_rd_burst_req,
    input  logic [9:0]               ch3_rd_burst_len,
    input  logic [23:0]              ch3_rd_burst_addr,
    output logic                     ch3_rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] ch3_rd_burst_data,
    output logic                     ch3_rd_burst_finish,

    output logic                     rd_burst_req,
    output logic [9:0]               rd_burst_len,
    output logic [23:0]              rd_burst_addr,
    input  logic                     rd_burst_data_valid,
    input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
    input  logic                     rd_burst_finish,
    output logic                     rd_timeout
);

    // Encoding is ordered so that (state - 1) = {channel, phase} for every non-IDLE state.
    typedef enum logic [4:0] {
        IDLE      = 5'd0,
        CH0_CHECK = 5'd1,  CH0_BEGIN = 5'd2,  CH0_READ = 5'd3,  CH0_END = 5'd4,
        CH1_CHECK = 5'd5,  CH1_BEGIN = 5'd6,  CH1_READ = 5'd7,  CH1_END = 5'd8,
        CH2_CHECK = 5'd9,  CH2_BEGIN = 5'd10, CH2_READ = 5'd11, CH2_END = 5'd12,
        CH3_CHECK = 5'd13, CH3_BEGIN = 5'd14, CH3_READ = 5'd15, CH3_END = 5'd16
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]  ch_req;
    logic [9:0]  ch_len  [4];
    logic [23:0] ch_addr [4];
    logic [3:0]  ch_go;

    logic        state_ok;
    logic [3:0]  state_idx;
    logic [1:0]  cur_ch;
    logic        in_begin;
    logic        in_read;
    logic        in_end;
    logic [3:0]  rd_sel;
    logic [3:0]  end_sel;

    logic        finish_d0;
    logic        finish_d1;
    logic        wdt_abort;

    assign ch_req     = {ch3_rd_burst_req, ch2_rd_burst_req, ch1_rd_burst_req, ch0_rd_burst_req};
    assign ch_len[0]  = ch0_rd_burst_len;
    assign ch_len[1]  = ch1_rd_burst_len;
    assign ch_len[2]  = ch2_rd_burst_len;
    assign ch_len[3]  = ch3_rd_burst_len;
    assign ch_addr[0] = ch0_rd_burst_addr;
    assign ch_addr[1] = ch1_rd_burst_addr;
    assign ch_addr[2] = ch2_rd_burst_addr;
    assign ch_addr[3] = ch3_rd_burst_addr;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            ch_go[i] = ch_req[i] && (ch_len[i] != '0);
        end
    end

    assign state_ok  = (state != IDLE) && (state <= CH3_END);
    assign state_idx = 4'(state - 5'd1);
    assign cur_ch    = state_idx[3:2];
    assign in_begin  = state_ok && (state_idx[1:0] == 2'd1);
    assign in_read   = state_ok && (state_idx[1:0] == 2'd2);
    assign in_end    = state_ok && (state_idx[1:0] == 2'd3);

    always_comb begin
        rd_sel  = '0;
        end_sel = '0;
        rd_sel[cur_ch]  = in_read;
        end_sel[cur_ch] = in_end;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = CH0_CHECK;
            CH0_CHECK: state_next = ch_go[0] ? CH0_BEGIN : CH1_CHECK;
            CH0_BEGIN: state_next = CH0_READ;
            CH0_READ:  state_next = finish_d1 ? CH0_END : (wdt_abort ? IDLE : CH0_READ);
            CH0_END:   state_next = CH1_CHECK;
            CH1_CHECK: state_next = ch_go[1] ? CH1_BEGIN : CH2_CHECK;
            CH1_BEGIN: state_next = CH1_READ;
            CH1_READ:  state_next = finish_d1 ? CH1_END : (wdt_abort ? IDLE : CH1_READ);
            CH1_END:   state_next = CH2_CHECK;
            CH2_CHECK: state_next = ch_go[2] ? CH2_BEGIN : CH3_CHECK;
            CH2_BEGIN: state_next = CH2_READ;
            CH2_READ:  state_next = finish_d1 ? CH2_END : (wdt_abort ? IDLE : CH2_READ);
            CH2_END:   state_next = CH3_CHECK;
            CH3_CHECK: state_next = ch_go[3] ? CH3_BEGIN : CH0_CHECK;
            CH3_BEGIN: state_next = CH3_READ;
            CH3_READ:  state_next = finish_d1 ? CH3_END : (wdt_abort ? IDLE : CH3_READ);
            CH3_END:   state_next = CH0_CHECK;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            finish_d0     <= 1'b0;
            finish_d1     <= 1'b0;
            rd_burst_req  <= 1'b0;
            rd_burst_len  <= '0;
            rd_burst_addr <= '0;
        end else begin
            state     <= state_next;
            finish_d0 <= rd_burst_finish;
            finish_d1 <= finish_d0;
            if (in_begin) begin
                rd_burst_req  <= 1'b1;
                rd_burst_len  <= ch_len[cur_ch];
                rd_burst_addr <= ch_addr[cur_ch];
            end else if (wdt_abort || rd_burst_data_valid || rd_burst_finish) begin
                rd_burst_req  <= 1'b0;
            end
        end
    end

`ifdef MEM_READ_ARBI_WDT_EN
    logic [15:0] wdt_cnt;

    // A finish already in flight wins over the watchdog on the same cycle.
    assign wdt_abort = in_read && !finish_d1 && (wdt_cnt > 16'd8000);

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            wdt_cnt    <= '0;
            rd_timeout <= 1'b0;
        end else begin
            rd_timeout <= wdt_abort;
            if ((state == IDLE) || in_begin) begin
                wdt_cnt <= '0;
            end else if (in_read && (wdt_cnt != '1)) begin
                wdt_cnt <= wdt_cnt + 16'd1;
            end
        end
    end
`else
    assign wdt_abort  = 1'b0;
    assign rd_timeout = 1'b0;
`endif

    assign ch0_rd_burst_data_valid = rd_sel[0] && rd_burst_data_valid;
    assign ch1_rd_burst_data_valid = rd_sel[1] && rd_burst_data_valid;
    assign ch2_rd_burst_data_valid = rd_sel[2] && rd_burst_data_valid;
    assign ch3_rd_burst_data_valid = rd_sel[3] && rd_burst_data_valid;

    assign ch0_rd_burst_data = rd_sel[0] ? rd_burst_data : '0;
    assign ch1_rd_burst_data = rd_sel[1] ? rd_burst_data : '0;
    assign ch2_rd_burst_data = rd_sel[2] ? rd_burst_data : '0;
    assign ch3_rd_burst_data = rd_sel[3] ? rd_burst_data : '0;

    assign ch0_rd_burst_finish = end_sel[0];
    assign ch1_rd_burst_finish = end_sel[1];
    assign ch2_rd_burst_finish = end_sel[2];
    assign ch3_rd_burst_finish = end_sel[3];

endmodule
